// File: rtl/phy_clk_div_if.sv
// phy_clk_div_if: control/status bundle of the programmable clock divider.
//
// Handshake (req/ack level-pulse): the requester raises div_req with a stable
// div_ratio and holds both until div_ack pulses for one cycle. div_ack means the
// code has been copied into the divider. A further load needs div_req to be
// seen low for at least one cycle first. div_ack is never back-pressured.
//
// dbg_state exposes the divider FSM encoding (0 IDLE, 1 RUN, 2 CHANGE).
interface phy_clk_div_if #(
  parameter int RATIO_W = 4
);
  logic               div_en;
  logic [RATIO_W-1:0] div_ratio;
  logic               div_req;
  logic               div_ack;
  logic               clk_div_out;
  logic               clk_en_pulse;
  logic               div_busy;
  logic [1:0]         dbg_state;

  modport master (
    output div_en, div_ratio, div_req,
    input  div_ack, clk_div_out, clk_en_pulse, div_busy, dbg_state
  );

  modport slave (
    input  div_en, div_ratio, div_req,
    output div_ack, clk_div_out, clk_en_pulse, div_busy, dbg_state
  );
endinterface

// File: rtl/phy_clk_div.sv
// phy_clk_div: glitch-free programmable integer clock divider (/1 .. /2^RATIO_W).
// The divide ratio is changed only on a period boundary, so clk_div_out never
// shows a runt phase, and stopping always completes the current period.
// Optional macro PHY_CLK_DIV_SYNC_EN: div_en/div_req pass through a two-flop
// synchronizer before use (adds two cycles of latency to every response).
module phy_clk_div #(
  parameter int RATIO_W = 4
) (
  input logic          clk,
  input logic          rst,
  phy_clk_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [RATIO_W-1:0] CNT_ONE = 1;
  localparam logic [RATIO_W:0]   HALF_BIAS = 2;

  state_t             state;
  logic [RATIO_W-1:0] ratio_q;
  logic [RATIO_W-1:0] cnt_q;
  logic               req_armed;
  logic               ack_q;
  logic               clk_q;
  logic               pulse_q;
  logic               busy_q;

  logic               en_use;
  logic               req_use;

`ifdef PHY_CLK_DIV_SYNC_EN
  logic [1:0] en_sync;
  logic [1:0] req_sync;

  // Two-flop synchronizers for the asynchronous control levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sync  <= 2'b00;
      req_sync <= 2'b00;
    end else begin
      en_sync  <= {en_sync[0], bus.div_en};
      req_sync <= {req_sync[0], bus.div_req};
    end
  end

  assign en_use  = en_sync[1];
  assign req_use = req_sync[1];
`else
  assign en_use  = bus.div_en;
  assign req_use = bus.div_req;
`endif

  state_t             state_n;
  logic [RATIO_W-1:0] ratio_n;
  logic [RATIO_W-1:0] cnt_n;
  logic [RATIO_W:0]   half_n;
  logic               terminal;
  logic               req_take;
  logic               load;
  logic               running_n;

  // Next-state logic: counting, ratio loading at period boundaries, stopping.
  always_comb begin
    terminal  = (cnt_q == ratio_q);
    // A request is taken once per low->high episode and never while acking.
    req_take  = req_use && req_armed && !ack_q;
    state_n   = state;
    ratio_n   = ratio_q;
    cnt_n     = '0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req_take) begin
          load    = 1'b1;
          ratio_n = bus.div_ratio;
        end
        if (en_use) begin
          state_n = RUN;
        end
      end
      RUN: begin
        cnt_n = terminal ? '0 : cnt_q + CNT_ONE;
        if (terminal && !en_use) begin
          // Period finished with the enable gone: stop, taking a coincident
          // request on this final boundary.
          state_n = IDLE;
          if (req_take) begin
            load    = 1'b1;
            ratio_n = bus.div_ratio;
          end
        end else if (req_take) begin
          state_n = CHANGE;
        end
      end
      CHANGE: begin
        cnt_n = terminal ? '0 : cnt_q + CNT_ONE;
        if (terminal) begin
          load    = 1'b1;
          ratio_n = bus.div_ratio;
          state_n = en_use ? RUN : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state_n == IDLE) begin
      cnt_n = '0;
    end
    running_n = (state_n != IDLE);
    // High phase length is ceil((R+1)/2) counts.
    half_n    = ({1'b0, ratio_n} + HALF_BIAS) >> 1;
  end

  // State, counter, ratio and all outputs register together from next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ratio_q   <= '0;
      cnt_q     <= '0;
      req_armed <= 1'b0;
      ack_q     <= 1'b0;
      clk_q     <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state   <= state_n;
      ratio_q <= ratio_n;
      cnt_q   <= cnt_n;
      if (load) begin
        req_armed <= 1'b0;
      end else if (!req_use) begin
        req_armed <= 1'b1;
      end
      ack_q   <= load;
      clk_q   <= running_n && ({1'b0, cnt_n} < half_n);
      pulse_q <= running_n && (cnt_n == ratio_n);
      busy_q  <= running_n;
    end
  end

  assign bus.div_ack      = ack_q;
  assign bus.clk_div_out  = clk_q;
  assign bus.clk_en_pulse = pulse_q;
  assign bus.div_busy     = busy_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_phy_clk_div.sv
// tb_phy_clk_div: scoreboard bench for phy_clk_div. Each output word is
// {div_busy, div_ack, clk_div_out, clk_en_pulse}. With PHY_CLK_DIV_SYNC_EN the
// whole expected stream is shifted by two cycles after each reset release.
module tb_phy_clk_div;
  localparam int RATIO_W = 4;
`ifdef PHY_CLK_DIV_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phy_clk_div_if #(.RATIO_W(RATIO_W)) bus ();

  phy_clk_div #(.RATIO_W(RATIO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] obs;
  assign obs = {bus.div_busy, bus.div_ack, bus.clk_div_out, bus.clk_en_pulse};

  int n_checks = 0;
  int n_errors = 0;
  int step_n   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic en, input logic req, input logic [RATIO_W-1:0] ratio);
    bus.div_en    = en;
    bus.div_req   = req;
    bus.div_ratio = ratio;
  endtask

  task automatic tick();
    logic [3:0] w;
    @(posedge clk);
    #1;
    step_n++;
    w = exp_q.pop_front();
    check($sformatf("step%0d", step_n), obs, w);
  endtask

  task automatic step(input logic [3:0] w);
    exp_q.push_back(w);
    tick();
  endtask

  task automatic restart_queue();
    exp_q.delete();
    repeat (LAT) exp_q.push_back(4'b0000);
  endtask

  // n full divided periods of ratio code r with inputs held steady.
  task automatic run_periods(input int r, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c <= r; c++) begin
        step({1'b1, 1'b0, (c < (r + 2) / 2) ? 1'b1 : 1'b0, (c == r) ? 1'b1 : 1'b0});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", obs, 4'b0000);
    check("rst_state", bus.dbg_state, 2'd0);
    #3 rst = 1'b0;
    restart_queue();
    repeat (3) step(4'b0000);

    // Code 3 loaded from IDLE, then /4: 2 high, 2 low, pulse every 4th
    drive(1'b0, 1'b1, 4'd3); step(4'b0100);
    drive(1'b1, 1'b0, 4'd3); run_periods(3, 3);

    // Request code 4 at cnt=1 of /4: load at cnt=3, ack next, hold req one extra cycle
    step(4'b1010); step(4'b1010);
    drive(1'b1, 1'b1, 4'd4);
    step(4'b1000); step(4'b1001); step(4'b1110); step(4'b1010);
    drive(1'b1, 1'b0, 4'd4);
    step(4'b1010); step(4'b1000); step(4'b1001);
    run_periods(4, 2);

    // Drop enable at cnt=1 of /5: period completes, then IDLE
    step(4'b1010); step(4'b1010);
    drive(1'b0, 1'b0, 4'd4);
    step(4'b1010); step(4'b1000); step(4'b1001); step(4'b0000); step(4'b0000);

    // Code 0: output and pulse high every running cycle
    drive(1'b0, 1'b1, 4'd0); step(4'b0100);
    drive(1'b1, 1'b0, 4'd0); repeat (5) step(4'b1011);
    drive(1'b0, 1'b0, 4'd0); step(4'b0000); step(4'b0000);

    // Code 15: 8 high / 8 low
    drive(1'b0, 1'b1, 4'd15); step(4'b0100);
    drive(1'b1, 1'b0, 4'd15); run_periods(15, 2);
    drive(1'b0, 1'b0, 4'd15); step(4'b0000); step(4'b0000);

    // Request coinciding with enable drop: load on final boundary, ack, IDLE
    drive(1'b0, 1'b1, 4'd1); step(4'b0100);
    drive(1'b1, 1'b0, 4'd1); run_periods(1, 2);
    step(4'b1010);
    drive(1'b0, 1'b1, 4'd2); step(4'b1001); step(4'b0100);
    drive(1'b0, 1'b0, 4'd2); step(4'b0000);
    drive(1'b1, 1'b0, 4'd2); run_periods(2, 1);
    drive(1'b0, 1'b0, 4'd2); step(4'b0000);

    // Reset mid-period at cnt=2 of /8
    drive(1'b0, 1'b1, 4'd7); step(4'b0100);
    drive(1'b1, 1'b0, 4'd7); step(4'b1010); step(4'b1010); step(4'b1010);
    #3 rst = 1'b1;
    #1;
    check("rst_async_outputs", obs, 4'b0000);
    check("rst_async_state", bus.dbg_state, 2'd0);
    @(posedge clk);
    #1;
    check("rst_held_outputs", obs, 4'b0000);
    #2 rst = 1'b0;
    restart_queue();
    // Enable still high: restarts with R=0 (continuous high and pulse)
    repeat (4) step(4'b1011);
    drive(1'b0, 1'b0, 4'd7); step(4'b0000); step(4'b0000);

    while (exp_q.size() > 0) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/phy_clk_div.md
PHY_CLK_DIV -- requirements
Module: phy_clk_div

Interface
REQ-001 SHALL have parameter RATIO_W, default 4, width of the ratio code (divide ratio = code+1, 1..2^RATIO_W).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port div_en  input  1  level; 1 = run divider, 0 = stop glitch-free.
REQ-005 SHALL have port div_ratio  input  RATIO_W  ratio code, sampled only as in REQ-013.
REQ-006 SHALL have port div_req  input  1  level request to load div_ratio; held until div_ack.
REQ-007 SHALL have port div_ack  output  1  one-cycle pulse; div_ratio has been loaded.
REQ-008 SHALL have port clk_div_out  output  1  registered divided clock.
REQ-009 SHALL have port clk_en_pulse  output  1  registered one-cycle pulse, once per divided period.
REQ-010 SHALL have port div_busy  output  1  high in RUN or CHANGE states.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, CHANGE; every output registered.
REQ-012 SHALL keep an internal ratio register R (reset 0, i.e. /1) and a period counter cnt counting 0..R, wrapping to 0 after R.
REQ-013 SHALL sample div_ratio into R only at a terminal count (cnt==R) while in CHANGE, or in IDLE when div_req is high; div_ack pulses the following cycle.
REQ-014 SHALL transition IDLE->RUN when div_en=1; cnt starts at 0 in the first RUN cycle.
REQ-015 SHALL transition RUN->CHANGE when div_req=1 and div_ack is low; CHANGE->RUN at the terminal count after loading R.
REQ-016 SHALL, when div_en falls in RUN or CHANGE, complete the current period (through terminal count), then go IDLE; no runt high or low phase on clk_div_out.
REQ-017 SHALL drive clk_div_out high for cnt < ceil((R+1)/2), low otherwise; R=0 holds clk_div_out high while running.
REQ-018 SHALL assert clk_en_pulse when cnt==R in RUN/CHANGE; R=0 gives clk_en_pulse continuously high.
REQ-019 SHALL, if div_req and falling div_en coincide, load R at the final terminal count, pulse div_ack, then go IDLE.
REQ-020 SHALL ignore div_req while div_ack is high (no double load); new request requires div_req low for at least one cycle.
REQ-021 SHALL hold clk_div_out=0, clk_en_pulse=0, div_busy=0 in IDLE.

Reset
REQ-022 SHALL, on rst=1 at any time including mid-period, immediately force state IDLE, R=0, cnt=0, clk_div_out=0, clk_en_pulse=0, div_ack=0, div_busy=0.
REQ-023 SHALL resume only via REQ-014 after rst deasserts; no pending request survives reset.

Configuration
REQ-024 SHALL support macro PHY_CLK_DIV_SYNC_EN: when defined, div_en and div_req pass through a two-flop synchronizer (reset 0) before use, adding exactly 2 cycles to every response latency; when undefined, they are used directly.

Verification
REQ-025 SHALL cover: rst release, div_en=1, ratio code 3 loaded from IDLE -> div_ack one cycle later, clk_div_out 2 high/2 low, clk_en_pulse every 4th cycle.
REQ-026 SHALL cover: running /4, div_req with code 4 at cnt=1 -> load at cnt=3, div_ack next cycle, then 3 high/2 low, pulse every 5 cycles.
REQ-027 SHALL cover: running /5, div_en dropped at cnt=1 -> period completes through cnt=4, then IDLE, div_busy=0, outputs 0, no runt phase.
REQ-028 SHALL cover: rst pulsed at cnt=2 of /8 -> all outputs 0 asynchronously, R=0 after release.
REQ-029 SHALL cover: ratio code 0 -> clk_div_out=1 and clk_en_pulse=1 every RUN cycle; code 15 -> 8 high/8 low.
REQ-030 SHALL cover: with PHY_CLK_DIV_SYNC_EN defined, repeat REQ-025 -> every edge delayed exactly 2 cycles.
